i2c_cfg_sequencer: RTL and testbench
====================================

Name: i2c_cfg_sequencer

Overview:
- Parametrised successor to the fixed single-packet I2C write generator.
- Walks a table of NUM_REGS codec register writes (WM8731-style 7-bit register address + 9-bit data) and frames each entry as a 24-bit I2C packet.
- Issues each packet to the downstream I2C bit-level master with a request/done handshake, retrying on NACK or timeout.
- Sits between codec-controller top-level boot logic and the I2C master.

Parameters:
- DEV_ADDR, 7'h1A, 7-bit codec device address; packet byte 0 = {DEV_ADDR, 1'b0}.
- NUM_REGS, 10, number of table entries sent per sequence (1..64).
- IDX_W, 6, width of tbl_idx; must satisfy 2**IDX_W >= NUM_REGS.
- MAX_RETRY, 3, additional attempts per entry after the first failure (0..15).
- TIMEOUT, 4096, cycles allowed in WAIT before an attempt counts as failed.
- START_DELAY, 16, idle cycles between start acceptance and the first packet (0 allowed).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to run the full table.
- tbl_idx  out  IDX_W  current table index to the external combinational ROM.
- tbl_data  in  16  ROM entry {reg_addr[6:0], reg_data[8:0]}, valid in the same cycle as tbl_idx.
- i2c_packet  out  24  {DEV_ADDR, 1'b0, tbl_data[15:0]}, registered.
- wr_i2c  out  1  one-cycle write request to the I2C master.
- i2c_done  in  1  one-cycle pulse from the master: transfer finished.
- i2c_ack_err  in  1  qualifies i2c_done: a NACK occurred.
- busy  out  1  high from start acceptance until DONE or FAIL is reached.
- done  out  1  sticky; all entries were acknowledged.
- error  out  1  sticky; an entry exhausted its retries.
- err_idx  out  IDX_W  index of the failing entry; valid while error=1.

Behaviour:
- Reset (asynchronous, rst_n low):
  - State = IDLE; tbl_idx = 0; i2c_packet = 0; wr_i2c, busy, done, error = 0; err_idx = 0; retry and timer counters cleared.
  - Reset taken mid-transfer abandons the sequence immediately. Nothing resumes after release.
- States: IDLE, DELAY, LOAD, REQ, WAIT, NEXT, DONE, FAIL.
- IDLE:
  - start=1 → DELAY. Clear done and error, set busy, tbl_idx=0, retry=0, delay counter=0.
  - start is ignored in every state except IDLE, DONE and FAIL.
  - From DONE or FAIL, start behaves exactly as it does in IDLE.
- DELAY: count START_DELAY cycles, then → LOAD. With START_DELAY=0, go DELAY → LOAD after one cycle.
- LOAD: register i2c_packet from {DEV_ADDR, 0, tbl_data} → REQ.
- REQ: wr_i2c=1 for exactly this cycle; clear timer → WAIT.
- WAIT: timer increments each cycle.
  - i2c_done=1 and i2c_ack_err=0 → NEXT.
  - i2c_done=1 and i2c_ack_err=1 → attempt failed.
  - Timer reaching TIMEOUT-1 without i2c_done → attempt failed.
  - If i2c_done and timeout occur in the same cycle, i2c_done wins.
  - i2c_ack_err without i2c_done is ignored.
- Failed attempt:
  - retry < MAX_RETRY → retry+1 → REQ. The packet is unchanged and not reloaded.
  - Otherwise → FAIL with err_idx = tbl_idx.
- NEXT: retry=0.
  - tbl_idx == NUM_REGS-1 → DONE.
  - Otherwise tbl_idx+1 → LOAD. tbl_idx never wraps.
- DONE: done=1, busy=0. Hold until the next start.
- FAIL: error=1, busy=0. Hold until the next start.
- i2c_done pulses outside WAIT are ignored.
- Latency:
  - start to first wr_i2c = START_DELAY+3 cycles (IDLE→DELAY, DELAY→LOAD, LOAD→REQ).
  - i2c_done to the next wr_i2c = 3 cycles (NEXT, LOAD, REQ).
- i2c_packet stays stable from LOAD until the next LOAD; it is held in DONE and FAIL.

Test Plan:
- Nominal run: NUM_REGS=3, ROM = {0x1E,0x000}, {0x06,0x062}, {0x12,0x001}; master returns done 10 cycles after each wr_i2c with no error.
  - Expect exactly 3 wr_i2c pulses with packets 0x343C00, 0x340C62, 0x342401, then done=1, busy=0, error=0.
- Single NACK: on entry 1, the first attempt returns ack_err=1.
  - Expect entry 1 resent with an identical packet; sequence completes with done=1; 4 wr_i2c pulses in total.
- Retry exhaustion: MAX_RETRY=2, entry 2 always NACKs.
  - Expect 3 attempts on entry 2, then error=1, err_idx=2, busy=0, done=0.
- Timeout: TIMEOUT=64, master never responds.
  - Expect a resend every 64+1 cycles; after MAX_RETRY+1 attempts, error=1 with err_idx=0.
- Reset mid-WAIT: assert rst_n=0 asynchronously between clock edges during entry 1.
  - Expect all outputs to 0 immediately, state IDLE, no wr_i2c after release until a new start.
- Start while busy, and restart after done:
  - Start pulses during WAIT are ignored (no extra pulses, tbl_idx unchanged).
  - A start after DONE clears done and replays from index 0 after START_DELAY+3 cycles.

Source files
------------

// File: rtl/i2c_cfg_sequencer_if.sv
// Request/done handshake between the codec config sequencer and the
// downstream I2C bit-level master.
interface i2c_cfg_sequencer_if;
  logic [23:0] i2c_packet;
  logic        wr_i2c;
  logic        i2c_done;
  logic        i2c_ack_err;

  modport master (
    output i2c_packet,
    output wr_i2c,
    input  i2c_done,
    input  i2c_ack_err
  );

  modport slave (
    input  i2c_packet,
    input  wr_i2c,
    output i2c_done,
    output i2c_ack_err
  );
endinterface

// File: rtl/i2c_cfg_sequencer.sv
// Walks a table of codec register writes and issues each one as a 24-bit
// I2C packet, retrying on NACK or timeout.
module i2c_cfg_sequencer #(
  parameter logic [6:0] DEV_ADDR    = 7'h1A,
  parameter int         NUM_REGS    = 10,
  parameter int         IDX_W       = 6,
  parameter int         MAX_RETRY   = 3,
  parameter int         TIMEOUT     = 4096,
  parameter int         START_DELAY = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic [IDX_W-1:0]     tbl_idx,
  input  logic [15:0]          tbl_data,
  i2c_cfg_sequencer_if.master  i2c,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [IDX_W-1:0]     err_idx
);

  typedef enum logic [2:0] {
    S_IDLE, S_DELAY, S_LOAD, S_REQ, S_WAIT, S_NEXT, S_DONE, S_FAIL
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   tbl_idx_q;
  logic [IDX_W-1:0]   err_idx_q;
  logic [23:0]        packet_q;
  logic [3:0]         retry_q;
  logic [15:0]        cnt_q;
  logic               attempt_fail;
  logic               can_retry;
  logic               last_entry;
  logic               start_ok;

  assign can_retry  = (retry_q < 4'(MAX_RETRY));
  assign last_entry = (tbl_idx_q == IDX_W'(NUM_REGS - 1));
  assign start_ok   = start && ((state_q == S_IDLE) || (state_q == S_DONE) ||
                                (state_q == S_FAIL));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; i2c_done takes priority over a coincident timeout
  always_comb begin
    state_d      = state_q;
    attempt_fail = 1'b0;
    case (state_q)
      S_IDLE, S_DONE, S_FAIL: begin
        if (start) state_d = S_DELAY;
      end
      S_DELAY: begin
        if (cnt_q == 16'(START_DELAY)) state_d = S_LOAD;
      end
      S_LOAD: state_d = S_REQ;
      S_REQ:  state_d = S_WAIT;
      S_WAIT: begin
        if (i2c.i2c_done) attempt_fail = i2c.i2c_ack_err;
        else              attempt_fail = (cnt_q == 16'(TIMEOUT - 1));
        if (i2c.i2c_done && !i2c.i2c_ack_err) state_d = S_NEXT;
        else if (attempt_fail)                state_d = can_retry ? S_REQ : S_FAIL;
      end
      S_NEXT: state_d = last_entry ? S_DONE : S_LOAD;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: table index, packet, retry count and the shared delay/timeout counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tbl_idx_q <= '0;
      err_idx_q <= '0;
      packet_q  <= '0;
      retry_q   <= '0;
      cnt_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE, S_FAIL: begin
          if (start_ok) begin
            tbl_idx_q <= '0;
            err_idx_q <= '0;
            retry_q   <= '0;
            cnt_q     <= '0;
          end
        end
        S_DELAY: cnt_q <= cnt_q + 16'd1;
        S_LOAD:  packet_q <= {DEV_ADDR, 1'b0, tbl_data};
        S_REQ:   cnt_q <= '0;
        S_WAIT: begin
          cnt_q <= cnt_q + 16'd1;
          if (attempt_fail) begin
            if (can_retry) retry_q   <= retry_q + 4'd1;
            else           err_idx_q <= tbl_idx_q;
          end
        end
        S_NEXT: begin
          retry_q <= '0;
          if (!last_entry) tbl_idx_q <= tbl_idx_q + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign tbl_idx        = tbl_idx_q;
  assign err_idx        = err_idx_q;
  assign i2c.i2c_packet = packet_q;
  assign i2c.wr_i2c     = (state_q == S_REQ);
  assign busy           = (state_q == S_DELAY) || (state_q == S_LOAD) ||
                          (state_q == S_REQ)   || (state_q == S_WAIT) ||
                          (state_q == S_NEXT);
  assign done           = (state_q == S_DONE);
  assign error          = (state_q == S_FAIL);

endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
// Directed bench for i2c_cfg_sequencer: a 3-entry ROM, a scripted I2C master
// responder, and a packet/timestamp monitor.
module tb_i2c_cfg_sequencer;

  localparam int IDX_W       = 6;
  localparam int START_DELAY = 4;
  localparam int PERIOD      = 10;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [IDX_W-1:0] tbl_idx;
  logic [15:0]      tbl_data;
  logic             busy;
  logic             done;
  logic             error;
  logic [IDX_W-1:0] err_idx;

  i2c_cfg_sequencer_if bus ();

  i2c_cfg_sequencer #(
    .DEV_ADDR   (7'h1A),
    .NUM_REGS   (3),
    .IDX_W      (IDX_W),
    .MAX_RETRY  (2),
    .TIMEOUT    (64),
    .START_DELAY(START_DELAY)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .tbl_idx (tbl_idx),
    .tbl_data(tbl_data),
    .i2c     (bus.master),
    .busy    (busy),
    .done    (done),
    .error   (error),
    .err_idx (err_idx)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [23:0] pkt_log[$];
  longint      wr_t[$];

  int nack_idx  = -1;
  int nack_left = 0;
  bit silent    = 1'b0;

  initial clk = 1'b0;
  always #(PERIOD/2) clk = ~clk;

  // Codec register ROM
  always_comb begin
    tbl_data = 16'h0000;
    case (tbl_idx)
      6'd0: tbl_data = {7'h1E, 9'h000};
      6'd1: tbl_data = {7'h06, 9'h062};
      6'd2: tbl_data = {7'h12, 9'h001};
      default: tbl_data = 16'h0000;
    endcase
  end

  // I2C master model: done pulse 10 cycles after each write request
  initial begin : responder
    int cd;
    bit pend_nack;
    cd = 0;
    pend_nack = 1'b0;
    bus.i2c_done    = 1'b0;
    bus.i2c_ack_err = 1'b0;
    forever begin
      @(negedge clk);
      bus.i2c_done    = 1'b0;
      bus.i2c_ack_err = 1'b0;
      if (cd > 0) begin
        cd = cd - 1;
        if (cd == 0) begin
          bus.i2c_done    = 1'b1;
          bus.i2c_ack_err = pend_nack;
        end
      end
      if (rst_n && bus.wr_i2c && !silent) begin
        cd = 10;
        pend_nack = (int'(tbl_idx) == nack_idx) && (nack_left > 0);
        if (pend_nack) nack_left = nack_left - 1;
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst_n && bus.wr_i2c) begin
        pkt_log.push_back(bus.i2c_packet);
        wr_t.push_back(longint'($time));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Pulses start for one cycle and returns cycles until the first wr_i2c
  task automatic apply_stimulus(output int lat);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!bus.wr_i2c && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_output({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin : stimulus
    int lat;
    int n;
    rst_n = 1'b0;
    start = 1'b0;

    repeat (2) @(negedge clk);
    check_output("rst_busy",   32'(busy),           32'd0);
    check_output("rst_done",   32'(done),           32'd0);
    check_output("rst_error",  32'(error),          32'd0);
    check_output("rst_wr",     32'(bus.wr_i2c),     32'd0);
    check_output("rst_packet", 32'(bus.i2c_packet), 32'd0);
    check_output("rst_idx",    32'(tbl_idx),        32'd0);
    check_output("rst_erridx", 32'(err_idx),        32'd0);
    rst_n = 1'b1;

    // Nominal run, with a start pulse injected during WAIT
    $display("[TB] nominal run");
    pkt_log.delete(); wr_t.delete();
    apply_stimulus(lat);
    check_output("nom_latency", 32'(lat), 32'(START_DELAY + 3));
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_output("busy_start_idx",  32'(tbl_idx), 32'd0);
    check_output("busy_start_busy", 32'(busy),    32'd1);
    wait_idle("nom");
    check_output("nom_count", 32'(pkt_log.size()), 32'd3);
    if (pkt_log.size() == 3) begin
      check_output("nom_pkt0", 32'(pkt_log[0]), 32'h343C00);
      check_output("nom_pkt1", 32'(pkt_log[1]), 32'h340C62);
      check_output("nom_pkt2", 32'(pkt_log[2]), 32'h342401);
      check_output("nom_gap",  32'(wr_t[1] - wr_t[0]), 32'(13 * PERIOD));
    end
    check_output("nom_done",  32'(done),           32'd1);
    check_output("nom_error", 32'(error),          32'd0);
    check_output("nom_hold",  32'(bus.i2c_packet), 32'h342401);
    check_output("nom_idx",   32'(tbl_idx),        32'd2);

    // Single NACK on entry 1, also a restart from DONE
    $display("[TB] single NACK");
    pkt_log.delete(); wr_t.delete();
    nack_idx = 1; nack_left = 1;
    apply_stimulus(lat);
    check_output("nack_latency", 32'(lat),  32'(START_DELAY + 3));
    check_output("nack_donecl",  32'(done), 32'd0);
    wait_idle("nack");
    check_output("nack_count", 32'(pkt_log.size()), 32'd4);
    if (pkt_log.size() == 4) begin
      check_output("nack_pkt1",  32'(pkt_log[1]), 32'h340C62);
      check_output("nack_pkt2",  32'(pkt_log[2]), 32'h340C62);
      check_output("nack_pkt3",  32'(pkt_log[3]), 32'h342401);
      check_output("nack_regap", 32'(wr_t[2] - wr_t[1]), 32'(11 * PERIOD));
    end
    check_output("nack_done",  32'(done),  32'd1);
    check_output("nack_error", 32'(error), 32'd0);

    // Entry 2 always NACKs: three attempts then FAIL
    $display("[TB] retry exhaustion");
    pkt_log.delete(); wr_t.delete();
    nack_idx = 2; nack_left = 100;
    apply_stimulus(lat);
    wait_idle("retry");
    check_output("retry_count", 32'(pkt_log.size()), 32'd5);
    if (pkt_log.size() == 5)
      check_output("retry_pkt4", 32'(pkt_log[4]), 32'h342401);
    check_output("retry_error",  32'(error),   32'd1);
    check_output("retry_erridx", 32'(err_idx), 32'd2);
    check_output("retry_done",   32'(done),    32'd0);
    check_output("retry_busy",   32'(busy),    32'd0);
    nack_idx = -1; nack_left = 0;

    // Master never answers: resend every 65 cycles, then FAIL on entry 0
    $display("[TB] timeout");
    pkt_log.delete(); wr_t.delete();
    silent = 1'b1;
    apply_stimulus(lat);
    check_output("tmo_errcl", 32'(error), 32'd0);
    wait_idle("tmo");
    check_output("tmo_count", 32'(pkt_log.size()), 32'd3);
    if (pkt_log.size() == 3) begin
      check_output("tmo_pkt2", 32'(pkt_log[2]), 32'h343C00);
      check_output("tmo_gap1", 32'(wr_t[1] - wr_t[0]), 32'(65 * PERIOD));
      check_output("tmo_gap2", 32'(wr_t[2] - wr_t[1]), 32'(65 * PERIOD));
    end
    check_output("tmo_error",  32'(error),   32'd1);
    check_output("tmo_erridx", 32'(err_idx), 32'd0);
    silent = 1'b0;

    // Asynchronous reset while waiting on entry 1
    $display("[TB] reset mid-WAIT");
    pkt_log.delete(); wr_t.delete();
    apply_stimulus(lat);
    n = 0;
    while (pkt_log.size() < 2 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check_output("mid_reach", 32'(pkt_log.size()), 32'd2);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("mid_busy",   32'(busy),           32'd0);
    check_output("mid_packet", 32'(bus.i2c_packet), 32'd0);
    check_output("mid_idx",    32'(tbl_idx),        32'd0);
    check_output("mid_error",  32'(error),          32'd0);
    check_output("mid_done",   32'(done),           32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    check_output("mid_nowr",  32'(pkt_log.size()), 32'd2);
    check_output("mid_idle",  32'(busy),           32'd0);

    // Fresh start after reset replays from index 0
    $display("[TB] restart after reset");
    pkt_log.delete(); wr_t.delete();
    apply_stimulus(lat);
    check_output("re_latency", 32'(lat), 32'(START_DELAY + 3));
    wait_idle("re");
    check_output("re_count", 32'(pkt_log.size()), 32'd3);
    if (pkt_log.size() == 3)
      check_output("re_pkt0", 32'(pkt_log[0]), 32'h343C00);
    check_output("re_done", 32'(done), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
